ascii_param_seq: RTL and testbench

ASCII_PARAM_SEQ -- requirements
Module: ascii_param_seq

---
 rtl/ascii_param_seq.sv | 159 +++++++++++++++
 tb/tb_ascii_param_seq.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_param_seq.sv
// Parameter file plus ASCII query streamer: loads 12 scoring words, then normalizes and round-robins query bytes to PEs.
// Latency: a parameter write or accepted byte is visible one cycle after its edge; done follows FLUSH by one cycle.
// Backpressure: in_ready is high only while streaming; in_valid gaps stall the stream indefinitely.
module ascii_param_seq #(
    parameter int PE_WIDTH = 10,
    parameter int NUM_PE   = 32,
    parameter int LEN_W    = 16,
    localparam int SEL_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr_en,
    input  logic [3:0]               cfg_addr,
    input  logic [PE_WIDTH-1:0]      cfg_data,
    input  logic                     start,
    input  logic [LEN_W-1:0]         query_len,
    input  logic [7:0]               in_char,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [12*PE_WIDTH-1:0]   param_out,
    output logic [7:0]               char_out,
    output logic                     char_valid,
    output logic [SEL_W-1:0]         pe_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [PE_WIDTH-1:0]  param_q [12];
    logic [11:0]          mask;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     count;
    logic [LEN_W-1:0]     count_inc;
    logic [SEL_W-1:0]     ptr;
    logic                 wr_ok;
    logic                 wr_bad;
    logic                 start_ok;
    logic                 start_bad;
    logic                 xfer;
    logic [7:0]           norm_char;

    // Decode this cycle's requests; a write in IDLE always wins over start.
    always_comb begin
        wr_ok     = 1'b0;
        wr_bad    = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        if (cfg_wr_en) begin
            if (state == IDLE && cfg_addr <= 4'd11) wr_ok  = 1'b1;
            else                                    wr_bad = 1'b1;
        end else if (start && state == IDLE) begin
            if (&mask) start_ok  = 1'b1;
            else       start_bad = 1'b1;
        end
        xfer      = in_valid && (state == STREAM);
        count_inc = count + 1'b1;
        norm_char = in_char;
        if (in_char >= 8'h61 && in_char <= 8'h7A) norm_char = in_char - 8'h20;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_n = (query_len == '0) ? FLUSH : STREAM;
            end
            STREAM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && count_inc == len_q) state_n = FLUSH;
            end
            FLUSH: begin
                busy    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Parameter words and written-mask; the mask only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 12; k++) param_q[k] <= '0;
            mask <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < 12; k++) begin
                if (cfg_addr == 4'(k)) begin
                    param_q[k] <= cfg_data;
                    mask[k]    <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 12; g++) begin : g_param
        assign param_out[g*PE_WIDTH +: PE_WIDTH] = param_q[g];
    end

    // Stream bookkeeping: latched length, character count and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            count <= '0;
            ptr   <= '0;
        end else if (start_ok) begin
            len_q <= query_len;
            count <= '0;
            ptr   <= '0;
        end else if (xfer) begin
            count <= count_inc;
            ptr   <= (ptr == SEL_W'(NUM_PE - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Output byte path: pe_sel carries the PE index of the byte presented alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            pe_sel     <= '0;
        end else begin
            char_valid <= xfer;
            if (start_ok) pe_sel <= '0;
            if (xfer) begin
                char_out <= norm_char;
                pe_sel   <= ptr;
            end
        end
    end

    // One-cycle status pulses: done on the first IDLE cycle after FLUSH, cfg_err after a rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= (state == FLUSH);
            cfg_err <= wr_bad || start_bad;
        end
    end

endmodule

// File: tb/tb_ascii_param_seq.sv
// Directed bench for ascii_param_seq with NUM_PE=4 so the round-robin wrap is exercised.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each task compares observed outputs against hand-computed values.
module tb_ascii_param_seq;

    localparam int PEW = 10;
    localparam int NPE = 4;
    localparam int LW  = 16;

    logic              clk;
    logic              rst_n;
    logic              cfg_wr_en;
    logic [3:0]        cfg_addr;
    logic [PEW-1:0]    cfg_data;
    logic              start;
    logic [LW-1:0]     query_len;
    logic [7:0]        in_char;
    logic              in_valid;
    logic              in_ready;
    logic [12*PEW-1:0] param_out;
    logic [7:0]        char_out;
    logic              char_valid;
    logic [1:0]        pe_sel;
    logic              busy;
    logic              done;
    logic              cfg_err;

    logic [12*PEW-1:0] exp_param;
    int                vectors;
    int                errors;

    ascii_param_seq #(.PE_WIDTH(PEW), .NUM_PE(NPE), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .query_len  (query_len),
        .in_char    (in_char),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .param_out  (param_out),
        .char_out   (char_out),
        .char_valid (char_valid),
        .pe_sel     (pe_sel),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [PEW-1:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_wr_en = 1'b0;
        if (a <= 4'd11 && !busy) exp_param[a*PEW +: PEW] = d;
    endtask

    task automatic pulse_start(input logic [LW-1:0] len);
        start     = 1'b1;
        query_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_param = '0;
    endtask

    task automatic load_words(input int last);
        for (int k = 0; k <= last; k++) write_word(4'(k), PEW'(k + 1));
    endtask

    task automatic test_reset();
        vectors++;
        if ({char_valid, in_ready, busy, done, cfg_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {char_valid, in_ready, busy, done, cfg_err});
        end
        vectors++;
        if (param_out !== '0) begin
            errors++;
            $display("FAIL reset_param: got %h expected 0", param_out);
        end
        vectors++;
        if ({char_out, pe_sel} !== 10'h0) begin
            errors++;
            $display("FAIL reset_char_sel: got %h/%0d expected 00/0", char_out, pe_sel);
        end
    endtask

    task automatic test_basic();
        logic [7:0] src [4];
        logic [7:0] exp [4];
        src = '{8'h61, 8'h63, 8'h67, 8'h54};
        exp = '{8'h41, 8'h43, 8'h47, 8'h54};
        load_words(11);
        vectors++;
        if (param_out[5*PEW +: PEW] !== 10'd6) begin
            errors++;
            $display("FAIL basic_word5: got %0d expected 6", param_out[5*PEW +: PEW]);
        end
        vectors++;
        if (param_out !== exp_param) begin
            errors++;
            $display("FAIL basic_param: got %h expected %h", param_out, exp_param);
        end
        pulse_start(16'd4);
        vectors++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL basic_stream_entry: got %b expected 11", {busy, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_char  = src[i];
            tick();
            vectors++;
            if ({char_valid, char_out, pe_sel} !== {1'b1, exp[i], 2'(i)}) begin
                errors++;
                $display("FAIL basic_char%0d: got v=%b %h sel=%0d expected v=1 %h sel=%0d",
                         i, char_valid, char_out, pe_sel, exp[i], i);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if ({busy, in_ready, done} !== 3'b100) begin
            errors++;
            $display("FAIL basic_flush: got busy/rdy/done %b expected 100", {busy, in_ready, done});
        end
        tick();
        vectors++;
        if ({busy, done, char_valid} !== 3'b010) begin
            errors++;
            $display("FAIL basic_done: got busy/done/cv %b expected 010", {busy, done, char_valid});
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got %b expected 0", done);
        end
    endtask

    task automatic test_incomplete_mask();
        do_reset();
        load_words(10);
        pulse_start(16'd1);
        vectors++;
        if ({cfg_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL mask_reject: got err/busy %b expected 10", {cfg_err, busy});
        end
        tick();
        vectors++;
        if ({cfg_err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL mask_reject_after: got err/busy %b expected 00", {cfg_err, busy});
        end
        write_word(4'd11, 10'd12);
        pulse_start(16'd1);
        vectors++;
        if ({cfg_err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL mask_accept: got err/busy %b expected 01", {cfg_err, busy});
        end
        in_valid = 1'b1;
        in_char  = 8'h7A;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({char_valid, char_out} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL norm_z: got v=%b %h expected v=1 5a", char_valid, char_out);
        end
        tick();
        tick();
    endtask

    task automatic test_wrap_gaps();
        logic [7:0] src [6];
        logic [7:0] exp [6];
        int sent, pulses, dones;
        logic x;
        src = '{8'h78, 8'h79, 8'h7B, 8'h60, 8'h41, 8'h7A};
        exp = '{8'h58, 8'h59, 8'h7B, 8'h60, 8'h41, 8'h5A};
        sent = 0; pulses = 0; dones = 0;
        pulse_start(16'd6);
        for (int c = 0; c < 30; c++) begin
            in_valid = (c % 2 == 0) && (sent < 6);
            in_char  = (sent < 6) ? src[sent] : 8'h00;
            x = in_valid && in_ready;
            tick();
            if (x) sent++;
            if (char_valid) begin
                if (pulses < 6) begin
                    vectors++;
                    if ({char_out, pe_sel} !== {exp[pulses], 2'(pulses % 4)}) begin
                        errors++;
                        $display("FAIL wrap_char%0d: got %h sel=%0d expected %h sel=%0d",
                                 pulses, char_out, pe_sel, exp[pulses], pulses % 4);
                    end
                end
                pulses++;
            end
            if (done) dones++;
        end
        in_valid = 1'b0;
        vectors++;
        if (pulses !== 6) begin
            errors++;
            $display("FAIL wrap_pulses: got %0d expected 6", pulses);
        end
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL wrap_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_zero_len();
        int cv;
        cv = 0;
        in_valid = 1'b1;
        in_char  = 8'h61;
        pulse_start(16'd0);
        if (char_valid) cv++;
        vectors++;
        if ({busy, in_ready, done} !== 3'b100) begin
            errors++;
            $display("FAIL zero_flush: got busy/rdy/done %b expected 100", {busy, in_ready, done});
        end
        tick();
        if (char_valid) cv++;
        vectors++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL zero_done: got busy/done %b expected 01", {busy, done});
        end
        tick();
        if (char_valid) cv++;
        in_valid = 1'b0;
        vectors++;
        if (cv !== 0) begin
            errors++;
            $display("FAIL zero_no_char: got %0d pulses expected 0", cv);
        end
    endtask

    task automatic test_bad_writes();
        write_word(4'd12, 10'h3FF);
        vectors++;
        if ({cfg_err, param_out} !== {1'b1, exp_param}) begin
            errors++;
            $display("FAIL addr12: got err=%b %h expected err=1 %h", cfg_err, param_out, exp_param);
        end
        tick();
        pulse_start(16'd2);
        write_word(4'd3, 10'h155);
        vectors++;
        if ({cfg_err, param_out} !== {1'b1, exp_param}) begin
            errors++;
            $display("FAIL busy_write: got err=%b %h expected err=1 %h", cfg_err, param_out, exp_param);
        end
        pulse_start(16'd0);
        vectors++;
        if ({busy, in_ready, cfg_err} !== 3'b110) begin
            errors++;
            $display("FAIL busy_start: got busy/rdy/err %b expected 110", {busy, in_ready, cfg_err});
        end
        in_valid = 1'b1;
        in_char  = 8'h31;
        tick();
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({char_out, pe_sel, busy} !== {8'h31, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL busy_stream_end: got %h sel=%0d busy=%b expected 31 sel=1 busy=1", char_out, pe_sel, busy);
        end
        tick();
        tick();
    endtask

    task automatic test_start_and_write();
        cfg_wr_en = 1'b1;
        cfg_addr  = 4'd0;
        cfg_data  = 10'd7;
        start     = 1'b1;
        query_len = 16'd3;
        tick();
        cfg_wr_en = 1'b0;
        start     = 1'b0;
        exp_param[0 +: PEW] = 10'd7;
        vectors++;
        if ({busy, cfg_err, param_out} !== {2'b00, exp_param}) begin
            errors++;
            $display("FAIL write_wins: got busy/err %b %h expected 00 %h", {busy, cfg_err}, param_out, exp_param);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        pulse_start(16'd5);
        in_valid = 1'b1;
        in_char  = 8'h68;
        tick();
        in_char  = 8'h69;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({char_valid, char_out, pe_sel} !== {1'b1, 8'h49, 2'd1}) begin
            errors++;
            $display("FAIL abort_pre: got v=%b %h sel=%0d expected v=1 49 sel=1", char_valid, char_out, pe_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({char_valid, in_ready, busy, done, cfg_err, char_out, pe_sel, param_out} !== '0) begin
            errors++;
            $display("FAIL abort_async: got flags %b char %h sel %0d param %h expected all 0",
                     {char_valid, in_ready, busy, done, cfg_err}, char_out, pe_sel, param_out);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
        end
        rst_n = 1'b1;
        exp_param = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d expected 0", dones);
        end
        pulse_start(16'd1);
        vectors++;
        if ({cfg_err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL abort_restart: got err/busy %b expected 10", {cfg_err, busy});
        end
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        exp_param = '0;
        rst_n     = 1'b0;
        cfg_wr_en = 1'b0;
        cfg_addr  = 4'd0;
        cfg_data  = '0;
        start     = 1'b0;
        query_len = '0;
        in_char   = 8'h00;
        in_valid  = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_incomplete_mask();
        test_wrap_gaps();
        test_zero_len();
        test_bad_writes();
        test_start_and_write();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
